// File: rtl/mmio_responder_if.sv
// mmio_responder_if: CPU second-port bus, input-FIFO producer handshake and
// responder outputs bundled for the I/O window responder.
//   slave  : responder side (samples CPU/producer, drives read data, LEDs, irq)
//   master : CPU/producer side
interface mmio_responder_if;
  logic [15:0] Addr;      // CPU access address
  logic [15:0] WrData;    // CPU write data
  logic        Read;      // one-cycle read strobe
  logic        Write;     // one-cycle write strobe
  logic [15:0] RdData;    // registered read data
  logic        RdValid;   // one-cycle response flag for in-window reads
  logic [15:0] InData;    // producer data
  logic        InValid;   // producer has data
  logic        InReady;   // FIFO can accept (count < 4)
  logic [15:0] LedOut;    // LED register
  logic        TimerIrq;  // sticky timer-expired flag

  modport slave (
    input  Addr, WrData, Read, Write, InData, InValid,
    output RdData, RdValid, InReady, LedOut, TimerIrq
  );

  modport master (
    output Addr, WrData, Read, Write, InData, InValid,
    input  RdData, RdValid, InReady, LedOut, TimerIrq
  );
endinterface

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped I/O responder for the window 0xFF00-0xFF07.
// Answers CPU reads with one-cycle latency and handles writes at the sampling
// edge. Holds an LED register, a 4-entry input FIFO fed by a valid/ready
// producer and, when MMIO_TIMER_EN is defined, a 16-bit reload timer with a
// sticky expired flag driving TimerIrq.
// Ports:
//   CLK  - system clock
//   RstN - asynchronous active-low reset
//   bus  - mmio_responder_if.slave (CPU bus, producer handshake, LED, irq)
// Offsets: 0 LED, 1 FIFO pop, 2 STATUS, 3 RELOAD, 4 COUNT, 5 TCTRL, 6-7 zero.
module mmio_responder (
  input  logic            CLK,
  input  logic            RstN,
  mmio_responder_if.slave bus
);
  localparam logic [12:0] WIN_BASE   = 13'h1FE0;
  localparam logic [2:0]  OFF_LED    = 3'd0;
  localparam logic [2:0]  OFF_FIFO   = 3'd1;
  localparam logic [2:0]  OFF_STATUS = 3'd2;
`ifdef MMIO_TIMER_EN
  localparam logic [2:0]  OFF_RELOAD = 3'd3;
  localparam logic [2:0]  OFF_COUNT  = 3'd4;
  localparam logic [2:0]  OFF_TCTRL  = 3'd5;
`endif

  logic [15:0]      led_q, led_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [3:0][15:0] fifo_q, fifo_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             underflow_q, underflow_d;
`ifdef MMIO_TIMER_EN
  logic [15:0]      reload_q, reload_d;
  logic [15:0]      tcount_q, tcount_d;
  logic             en_q, en_d;
  logic             expired_q, expired_d;
`endif

  logic        hit, rd_hit, wr_hit, in_ready, push, pop;
  logic [2:0]  off;
  logic        expired;
  logic [15:0] status, rd_mux;

  // Decode and handshake. InReady looks only at the registered count, so a
  // pop never opens a slot for a push on the same edge.
  always_comb begin
    hit      = (bus.Addr[15:3] == WIN_BASE);
    off      = bus.Addr[2:0];
    rd_hit   = bus.Read && hit;
    wr_hit   = bus.Write && hit;
    in_ready = (count_q != 3'd4);
    push     = bus.InValid && in_ready;
    pop      = rd_hit && (off == OFF_FIFO) && (count_q != 3'd0);
  end

`ifdef MMIO_TIMER_EN
  always_comb expired = expired_q;
`else
  always_comb expired = 1'b0;
`endif

  always_comb begin
    status = {9'd0, expired, underflow_q, count_q == 3'd4, count_q == 3'd0, count_q};
    rd_mux = 16'd0;
    case (off)
      OFF_LED:    rd_mux = led_q;
      OFF_FIFO:   rd_mux = (count_q != 3'd0) ? fifo_q[rd_ptr_q] : 16'd0;
      OFF_STATUS: rd_mux = status;
`ifdef MMIO_TIMER_EN
      OFF_RELOAD: rd_mux = reload_q;
      OFF_COUNT:  rd_mux = tcount_q;
`endif
      default:    rd_mux = 16'd0;
    endcase
  end

  // Read path, LED and FIFO next state. Read data comes from the _q values,
  // so a simultaneous write returns the pre-write contents.
  always_comb begin
    rd_valid_d  = rd_hit;
    rd_data_d   = rd_data_q;
    led_d       = led_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;

    // Any read strobe replaces RdData; out-of-window reads return 0.
    if (bus.Read) rd_data_d = hit ? rd_mux : 16'd0;

    if (wr_hit && (off == OFF_LED)) led_d = bus.WrData;

    if (push) begin
      fifo_d[wr_ptr_q] = bus.InData;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    if (rd_hit && (off == OFF_FIFO) && (count_q == 3'd0)) underflow_d = 1'b1;
    else if (rd_hit && (off == OFF_STATUS))               underflow_d = 1'b0;
  end

`ifdef MMIO_TIMER_EN
  // Timer: clear is applied before the tick so a same-edge expiry wins;
  // a RELOAD write is applied last so it overrides the decrement.
  always_comb begin
    reload_d  = reload_q;
    tcount_d  = tcount_q;
    en_d      = en_q;
    expired_d = expired_q;

    if (wr_hit && (off == OFF_TCTRL)) begin
      en_d = bus.WrData[0];
      if (bus.WrData[1]) expired_d = 1'b0;
    end

    if (en_q && (reload_q != 16'd0)) begin
      if (tcount_q == 16'd1) begin
        tcount_d  = reload_q;
        expired_d = 1'b1;
      end else if (tcount_q != 16'd0) begin
        tcount_d = tcount_q - 16'd1;
      end
    end

    if (wr_hit && (off == OFF_RELOAD)) begin
      reload_d = bus.WrData;
      tcount_d = bus.WrData;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RstN) begin
    if (!RstN) begin
      led_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
`ifdef MMIO_TIMER_EN
      reload_q    <= '0;
      tcount_q    <= '0;
      en_q        <= 1'b0;
      expired_q   <= 1'b0;
`endif
    end else begin
      led_q       <= led_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
`ifdef MMIO_TIMER_EN
      reload_q    <= reload_d;
      tcount_q    <= tcount_d;
      en_q        <= en_d;
      expired_q   <= expired_d;
`endif
    end
  end

  assign bus.RdData   = rd_data_q;
  assign bus.RdValid  = rd_valid_q;
  assign bus.InReady  = in_ready;
  assign bus.LedOut   = led_q;
  assign bus.TimerIrq = expired;
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed plus randomized stimulus for mmio_responder,
// checked every cycle against a transaction-level reference model (queue
// FIFO, plain variables for registers). Timer checks need MMIO_TIMER_EN.
module tb_mmio_responder;
  logic CLK  = 1'b0;
  logic RstN = 1'b0;

  mmio_responder_if bus();
  mmio_responder dut (.CLK(CLK), .RstN(RstN), .bus(bus));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0] m_led, m_rdata, m_reload, m_tcnt;
  logic        m_rvalid, m_uf, m_en, m_exp;
  logic [15:0] m_q[$];

  task automatic m_reset();
    m_led = 0; m_rdata = 0; m_reload = 0; m_tcnt = 0;
    m_rvalid = 0; m_uf = 0; m_en = 0; m_exp = 0;
    m_q.delete();
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] off);
    case (off)
      3'd0: return m_led;
      3'd1: return (m_q.size() > 0) ? m_q[0] : 16'h0;
      3'd2: return {9'd0, m_exp, m_uf, m_q.size() == 4, m_q.size() == 0, 3'(m_q.size())};
`ifdef MMIO_TIMER_EN
      3'd3: return m_reload;
      3'd4: return m_tcnt;
`endif
      default: return 16'h0;
    endcase
  endfunction

  // One bus cycle: drive after the falling edge, advance the model, check
  // everything just after the rising edge.
  task automatic step(input logic rd, input logic wr, input logic [15:0] a,
                      input logic [15:0] wd, input logic iv, input logic [15:0] id,
                      input string tag);
    logic       hit, push;
    logic [2:0] off;
    logic [15:0] ntc;
    logic        nexp;
    @(negedge CLK);
    bus.Read = rd; bus.Write = wr; bus.Addr = a; bus.WrData = wd;
    bus.InValid = iv; bus.InData = id;
    hit  = (a >= 16'hFF00) && (a <= 16'hFF07);
    off  = a[2:0];
    push = iv && (m_q.size() < 4);
    m_rvalid = rd && hit;
    if (rd) m_rdata = hit ? m_read(off) : 16'h0;
    if (rd && hit && off == 3'd1) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_uf = 1'b1;
    end else if (rd && hit && off == 3'd2) m_uf = 1'b0;
    if (push) m_q.push_back(id);
    if (wr && hit && off == 3'd0) m_led = wd;
`ifdef MMIO_TIMER_EN
    ntc = m_tcnt; nexp = m_exp;
    if (wr && hit && off == 3'd5 && wd[1]) nexp = 1'b0;
    if (m_en && m_reload != 0) begin
      if (m_tcnt == 1) begin ntc = m_reload; nexp = 1'b1; end
      else if (m_tcnt != 0) ntc = m_tcnt - 1;
    end
    if (wr && hit && off == 3'd3) begin m_reload = wd; ntc = wd; end
    if (wr && hit && off == 3'd5) m_en = wd[0];
    m_tcnt = ntc; m_exp = nexp;
`else
    ntc = 0; nexp = 0;
`endif
    @(posedge CLK); #1;
    chk({tag, ".rvalid"}, bus.RdValid, m_rvalid);
    chk({tag, ".rdata"},  bus.RdData,  m_rdata);
    chk({tag, ".led"},    bus.LedOut,  m_led);
    chk({tag, ".inrdy"},  bus.InReady, m_q.size() < 4);
    chk({tag, ".irq"},    bus.TimerIrq, m_exp);
  endtask

  task automatic rd(input logic [15:0] a, input string tag);
    step(1'b1, 1'b0, a, 16'h0, 1'b0, 16'h0, tag);
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d, input string tag);
    step(1'b0, 1'b1, a, d, 1'b0, 16'h0, tag);
  endtask
  task automatic idle(input string tag);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, tag);
  endtask

  initial begin
    logic [15:0] pop_exp[4];
    bus.Read = 0; bus.Write = 0; bus.Addr = 0; bus.WrData = 0;
    bus.InValid = 0; bus.InData = 0;
    m_reset();

    // Reset values
    #12;
    chk("rst.rdata", bus.RdData, 16'h0);
    chk("rst.rvalid", bus.RdValid, 1'b0);
    chk("rst.led", bus.LedOut, 16'h0);
    chk("rst.irq", bus.TimerIrq, 1'b0);
    chk("rst.inrdy", bus.InReady, 1'b1);
    #5 RstN = 1'b1;

    // LED write/read
    rd(16'hFF00, "led_rd0");
    chk("led_rd0.val", {bus.RdValid, bus.RdData}, {1'b1, 16'h0000});
    idle("led_gap");
    chk("led_rvalid_drop", bus.RdValid, 1'b0);
    wr(16'hFF00, 16'hA5A5, "led_wr");
    chk("led_out", bus.LedOut, 16'hA5A5);
    rd(16'hFF00, "led_rd1");
    chk("led_rd1.val", bus.RdData, 16'hA5A5);

    // FIFO fill and order
    for (int i = 1; i <= 4; i++) step(0, 0, 16'h0, 16'h0, 1, 16'(i), "push");
    chk("fifo_full_inrdy", bus.InReady, 1'b0);
    rd(16'hFF02, "st_full");
    chk("st_full.val", bus.RdData, 16'h0014);
    for (int i = 1; i <= 5; i++) begin
      rd(16'hFF01, "pop");
      chk("pop.val", bus.RdData, (i <= 4) ? 16'(i) : 16'h0);
    end
    rd(16'hFF02, "st_uf");
    chk("st_uf.val", bus.RdData, 16'h0028);
    rd(16'hFF02, "st_uf_clr");
    chk("st_uf_clr.val", bus.RdData, 16'h0008);

    // Full FIFO with a pop while the producer keeps offering
    for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 16'h0, 1, 16'h10 + 16'(i), "push2");
    step(1, 0, 16'hFF01, 16'h0, 1, 16'h0099, "pop_full");
    chk("pop_full.val", bus.RdData, 16'h0010);
    chk("pop_full.inrdy", bus.InReady, 1'b1);
    step(0, 0, 16'h0, 16'h0, 1, 16'h0099, "push_late");
    chk("push_late.inrdy", bus.InReady, 1'b0);
    pop_exp = '{16'h11, 16'h12, 16'h13, 16'h99};
    for (int i = 0; i < 4; i++) begin
      rd(16'hFF01, "pop2");
      chk("pop2.val", bus.RdData, pop_exp[i]);
    end

    // Out-of-window and simultaneous read/write
    step(0, 0, 16'h0, 16'h0, 1, 16'h0055, "push3");
    rd(16'hFEFF, "oow");
    chk("oow.val", {bus.RdValid, bus.RdData}, {1'b0, 16'h0});
    rd(16'hFF02, "oow_st");
    chk("oow_st.val", bus.RdData, 16'h0001);
    rd(16'hFF01, "pop3");
    step(1, 1, 16'hFF00, 16'h1234, 0, 16'h0, "rw");
    chk("rw.rdata", bus.RdData, 16'hA5A5);
    chk("rw.led", bus.LedOut, 16'h1234);

`ifdef MMIO_TIMER_EN
    wr(16'hFF03, 16'd3, "reload");
    wr(16'hFF05, 16'd1, "tctrl_en");
    idle("t1");
    idle("t2");
    chk("timer_pre", bus.TimerIrq, 1'b0);
    idle("t3");
    chk("timer_irq", bus.TimerIrq, 1'b1);
    rd(16'hFF04, "tcount");
    chk("tcount.val", bus.RdData, 16'd3);
    wr(16'hFF05, 16'd3, "tctrl_clr");
    chk("timer_clr", bus.TimerIrq, 1'b0);
    for (int i = 0; i < 4; i++) idle("t_run");
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a, d;
      a = 16'hFEFC + 16'($urandom_range(0, 15));
      d = ($urandom % 2) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      step(1'($urandom % 2), 1'($urandom % 4 == 0), a, d,
           1'($urandom % 2), 16'($urandom), "rnd");
    end

    // Asynchronous reset mid-stream
    wr(16'hFF00, 16'hFFFF, "pre_led");
    rd(16'hFF02, "pre_st");
    while (m_q.size() > 0) rd(16'hFF01, "drain");
    step(0, 0, 16'h0, 16'h0, 1, 16'h0A0A, "pre_push");
    step(0, 0, 16'h0, 16'h0, 1, 16'h0B0B, "pre_push");
`ifdef MMIO_TIMER_EN
    wr(16'hFF03, 16'd5, "pre_reload");
    wr(16'hFF05, 16'd1, "pre_en");
`endif
    rd(16'hFF00, "pre_rd");
    chk("pre_rd.val", bus.RdData, 16'hFFFF);
    bus.Read = 0; bus.Write = 0; bus.InValid = 0;
    #2 RstN = 1'b0;
    #1;
    m_reset();
    chk("arst.rdata", bus.RdData, 16'h0);
    chk("arst.rvalid", bus.RdValid, 1'b0);
    chk("arst.led", bus.LedOut, 16'h0);
    chk("arst.irq", bus.TimerIrq, 1'b0);
    chk("arst.inrdy", bus.InReady, 1'b1);
    #4 RstN = 1'b1;
    rd(16'hFF02, "post_st");
    chk("post_st.val", bus.RdData, 16'h0008);
    rd(16'hFF04, "post_cnt");
    chk("post_cnt.val", bus.RdData, 16'h0);
    idle("end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
